// File: rtl/cpu_step_controller.sv
// Debug clock generator for single-stepping or free-running a CPU under test,
// with halt request, breakpoint stop and a count of issued clock periods.
module cpu_step_controller #(
  parameter int p_data_width  = 16,
  parameter int p_half_period = 4,
  parameter int p_count_width = 16
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_reset,
  input  logic                     i_w_step,
  input  logic                     i_w_run,
  input  logic                     i_w_halt,
  input  logic                     i_w_bp_enable,
  input  logic [p_data_width-1:0]  i_w_bp_value,
  input  logic [p_data_width-1:0]  i_w_cpu_state,
  output logic                     o_w_debug_clk,
  output logic                     o_w_running,
  output logic                     o_w_bp_hit,
  output logic [p_count_width-1:0] o_w_cycle_count
);

  localparam int unsigned PW = (p_half_period > 1) ? $clog2(p_half_period) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(p_half_period - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP_HIGH,
    STEP_LOW,
    RUN_HIGH,
    RUN_LOW
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] phase, phase_nx;
  logic          phase_end;
  logic          halt_pend, halt_pend_nx;
  logic          bp_hit_nx;
  logic          bp_match;
  logic          bump;

  always_comb begin
    state_nx     = state;
    halt_pend_nx = halt_pend;
    bp_hit_nx    = o_w_bp_hit;
    bump         = 1'b0;
    phase_end    = (phase == PHASE_LAST);
    bp_match     = i_w_bp_enable && (i_w_cpu_state == i_w_bp_value);

    case (state)
      IDLE: begin
        halt_pend_nx = 1'b0;
        if (i_w_halt) begin
          state_nx = IDLE;
        end else if (i_w_run) begin
          state_nx  = RUN_HIGH;
          bump      = 1'b1;
          bp_hit_nx = 1'b0;
        end else if (i_w_step) begin
          state_nx  = STEP_HIGH;
          bump      = 1'b1;
          bp_hit_nx = 1'b0;
        end
      end
      STEP_HIGH: if (phase_end) state_nx = STEP_LOW;
      STEP_LOW:  if (phase_end) state_nx = IDLE;
      RUN_HIGH: begin
        halt_pend_nx = halt_pend | i_w_halt;
        if (phase_end) state_nx = RUN_LOW;
      end
      RUN_LOW: begin
        // a halt arriving on the very last LOW cycle still stops this period
        halt_pend_nx = halt_pend | i_w_halt;
        if (phase_end) begin
          if (halt_pend_nx || bp_match) begin
            state_nx     = IDLE;
            halt_pend_nx = 1'b0;
            if (bp_match) bp_hit_nx = 1'b1;
          end else begin
            state_nx = RUN_HIGH;
            bump     = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    phase_nx = (state == IDLE || phase_end) ? '0 : phase + PW'(1);
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state           <= IDLE;
      phase           <= '0;
      halt_pend       <= 1'b0;
      o_w_debug_clk   <= 1'b0;
      o_w_running     <= 1'b0;
      o_w_bp_hit      <= 1'b0;
      o_w_cycle_count <= '0;
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      halt_pend     <= halt_pend_nx;
      o_w_debug_clk <= (state_nx == STEP_HIGH) || (state_nx == RUN_HIGH);
      o_w_running   <= (state_nx == RUN_HIGH) || (state_nx == RUN_LOW);
      o_w_bp_hit    <= bp_hit_nx;
      if (bump) o_w_cycle_count <= o_w_cycle_count + p_count_width'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed self-checking bench for cpu_step_controller: step, run/halt,
// breakpoint, request priority, mid-run reset and counter wrap.
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0, run = 1'b0, halt = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_val = '0;
  logic [15:0] cpu_state;
  logic        dclk, running, bp_hit;
  logic [15:0] count;

  logic        w_step = 1'b0;
  logic        w_dclk, w_running, w_bp_hit;
  logic [3:0]  w_count;

  logic [15:0] rise_cnt = '0;
  logic [15:0] base = '0;
  logic [15:0] fixed = '0;
  logic        adv = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // CPU state word advances once per debug-clock rise when adv is set
  always @(posedge dclk) rise_cnt <= rise_cnt + 16'd1;
  assign cpu_state = adv ? (rise_cnt - base) : fixed;

  cpu_step_controller #(
    .p_data_width (16),
    .p_half_period(2),
    .p_count_width(16)
  ) dut (
    .i_w_clk        (clk),
    .i_w_reset      (rst),
    .i_w_step       (step),
    .i_w_run        (run),
    .i_w_halt       (halt),
    .i_w_bp_enable  (bp_en),
    .i_w_bp_value   (bp_val),
    .i_w_cpu_state  (cpu_state),
    .o_w_debug_clk  (dclk),
    .o_w_running    (running),
    .o_w_bp_hit     (bp_hit),
    .o_w_cycle_count(count)
  );

  cpu_step_controller #(
    .p_data_width (16),
    .p_half_period(1),
    .p_count_width(4)
  ) dut_w (
    .i_w_clk        (clk),
    .i_w_reset      (rst),
    .i_w_step       (w_step),
    .i_w_run        (1'b0),
    .i_w_halt       (1'b0),
    .i_w_bp_enable  (1'b0),
    .i_w_bp_value   (16'h0000),
    .i_w_cpu_state  (16'h0000),
    .o_w_debug_clk  (w_dclk),
    .o_w_running    (w_running),
    .o_w_bp_hit     (w_bp_hit),
    .o_w_cycle_count(w_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    check_eq("rst_dclk", dclk, 0);
    check_eq("rst_run", running, 0);
    check_eq("rst_bp", bp_hit, 0);
    check_eq("rst_cnt", count, 0);
    check_eq("rst_wcnt", w_count, 0);

    // single step, with a step pulse during STEP_LOW that must be dropped
    step = 1'b1; tick(); step = 1'b0;
    check_eq("st_e1_dclk", dclk, 1);
    check_eq("st_e1_cnt", count, 1);
    check_eq("st_e1_run", running, 0);
    tick(); check_eq("st_e2_dclk", dclk, 1);
    tick(); check_eq("st_e3_dclk", dclk, 0);
    step = 1'b1; tick(); step = 1'b0;
    check_eq("st_e4_dclk", dclk, 0);
    tick(); check_eq("st_e5_dclk", dclk, 0);
    check_eq("st_e5_cnt", count, 1);
    tick(); check_eq("st_noq_dclk", dclk, 0);
    check_eq("st_noq_cnt", count, 1);

    // free run, halt in RUN_HIGH of the 3rd period
    do_reset();
    run = 1'b1; tick(); run = 1'b0;
    check_eq("rn_start_run", running, 1);
    check_eq("rn_start_cnt", count, 1);
    for (int i = 0; i < 8; i++) begin
      step = (i == 3);
      run  = (i == 5);
      tick();
    end
    step = 1'b0; run = 1'b0;
    check_eq("rn_p3_dclk", dclk, 1);
    check_eq("rn_p3_cnt", count, 3);
    halt = 1'b1; tick(); halt = 1'b0;
    check_eq("rn_h_dclk", dclk, 1);
    tick(); check_eq("rn_low_dclk", dclk, 0);
    check_eq("rn_low_run", running, 1);
    tick(); check_eq("rn_low2_run", running, 1);
    tick(); check_eq("rn_stop_run", running, 0);
    check_eq("rn_stop_cnt", count, 3);
    check_eq("rn_stop_bp", bp_hit, 0);
    tick(); check_eq("rn_idle_cnt", count, 3);

    // breakpoint on cpu_state == 5 with state advancing per rise
    do_reset();
    bp_en = 1'b1; bp_val = 16'h0005;
    base = rise_cnt; adv = 1'b1;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check_eq("bp_pre_run", running, 1);
    tick();
    check_eq("bp_stop_run", running, 0);
    check_eq("bp_stop_hit", bp_hit, 1);
    check_eq("bp_stop_cnt", count, 5);
    step = 1'b1; tick(); step = 1'b0;
    check_eq("bp_clr_hit", bp_hit, 0);
    check_eq("bp_clr_cnt", count, 6);
    tick(); tick(); tick();

    // run started with state already at the breakpoint: one full period
    adv = 1'b0; fixed = 16'h0005;
    tick();
    run = 1'b1; tick(); run = 1'b0;
    check_eq("bp0_cnt", count, 7);
    tick(); tick(); tick();
    check_eq("bp0_pre_run", running, 1);
    tick();
    check_eq("bp0_stop_run", running, 0);
    check_eq("bp0_hit", bp_hit, 1);
    check_eq("bp0_cnt_end", count, 7);

    // halt + run + step together in IDLE: nothing starts
    bp_en = 1'b0;
    do_reset();
    run = 1'b1; step = 1'b1; halt = 1'b1; tick();
    run = 1'b0; step = 1'b0; halt = 1'b0;
    check_eq("pri_all_run", running, 0);
    check_eq("pri_all_dclk", dclk, 0);
    tick(); check_eq("pri_all_cnt", count, 0);
    run = 1'b1; step = 1'b1; tick();
    run = 1'b0; step = 1'b0;
    check_eq("pri_rs_run", running, 1);
    check_eq("pri_rs_cnt", count, 1);

    // reset during RUN_HIGH
    check_eq("mr_pre_dclk", dclk, 1);
    do_reset();
    check_eq("mr_dclk", dclk, 0);
    check_eq("mr_cnt", count, 0);
    check_eq("mr_run", running, 0);
    check_eq("mr_bp", bp_hit, 0);

    // 4-bit counter wrap on the half-period-1 instance
    for (int n = 1; n <= 17; n++) begin
      w_step = 1'b1; tick(); w_step = 1'b0;
      if (n == 1) check_eq("w_first_dclk", w_dclk, 1);
      if (n == 15) check_eq("w_cnt15", w_count, 15);
      if (n == 16) check_eq("w_cnt16", w_count, 0);
      tick();
      if (n == 1) check_eq("w_low_dclk", w_dclk, 0);
      tick();
    end
    check_eq("w_cnt17", w_count, 1);
    check_eq("w_run", w_running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 SHALL have parameter p_data_width, default 16, width of CPU state word and breakpoint value.
REQ-002 SHALL have parameter p_half_period, default 4, main-clock cycles per debug-clock half-period (legal range >=1).
REQ-003 SHALL have parameter p_count_width, default 16, width of executed-cycle counter.
REQ-004 SHALL have port i_w_clk  input  1  main clock; the only clock; all logic on rising edge.
REQ-005 SHALL have port i_w_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_w_step  input  1  single-cycle pulse (pre-debounced), request one CPU clock period.
REQ-007 SHALL have port i_w_run  input  1  single-cycle pulse, request free-running CPU clock.
REQ-008 SHALL have port i_w_halt  input  1  single-cycle pulse, request stop of free run.
REQ-009 SHALL have port i_w_bp_enable  input  1  level, breakpoint compare enable.
REQ-010 SHALL have port i_w_bp_value  input  p_data_width  breakpoint compare value.
REQ-011 SHALL have port i_w_cpu_state  input  p_data_width  CPU state word from the debugged CPU.
REQ-012 SHALL have port o_w_debug_clk  output  1  generated CPU clock, driven directly from a register.
REQ-013 SHALL have port o_w_running  output  1  high while in RUN_HIGH or RUN_LOW.
REQ-014 SHALL have port o_w_bp_hit  output  1  sticky flag, free run stopped by breakpoint.
REQ-015 SHALL have port o_w_cycle_count  output  p_count_width  number of CPU clock rising edges issued.

Function
REQ-016 SHALL implement FSM states IDLE, STEP_HIGH, STEP_LOW, RUN_HIGH, RUN_LOW.
REQ-017 SHALL hold a phase counter; each HIGH/LOW state lasts exactly p_half_period cycles; o_w_debug_clk=1 in *_HIGH, 0 otherwise.
REQ-018 SHALL, in IDLE, accept requests with priority halt > run > step; halt in IDLE is a no-op; accepted run -> RUN_HIGH, accepted step -> STEP_HIGH next cycle.
REQ-019 SHALL raise o_w_debug_clk one cycle after the accepting edge (request at edge t -> debug_clk high from t+1 through t+p_half_period).
REQ-020 SHALL increment o_w_cycle_count by 1 on every entry into STEP_HIGH or RUN_HIGH; wrap from 2^p_count_width-1 to 0.
REQ-021 SHALL go STEP_HIGH -> STEP_LOW -> IDLE; step/run/halt during STEP_* ignored (not queued).
REQ-022 SHALL go RUN_HIGH -> RUN_LOW; at end of RUN_LOW go IDLE if halt pending or breakpoint match, else RUN_HIGH.
REQ-023 SHALL latch i_w_halt in a halt-pending register while in RUN_*; never truncate a half-period; clear pending on entry to IDLE.
REQ-024 SHALL evaluate breakpoint match = i_w_bp_enable AND (i_w_cpu_state == i_w_bp_value), sampled on the final cycle of RUN_LOW only; no check in STEP_* or IDLE.
REQ-025 SHALL set o_w_bp_hit when leaving RUN_LOW due to match (also when halt pending simultaneously); clear it when a step or run is accepted.
REQ-026 SHALL, on run started while i_w_cpu_state already equals i_w_bp_value, issue at least one full period before stopping.
REQ-027 SHALL ignore i_w_run and i_w_step while in RUN_*.

Reset
REQ-028 SHALL on i_w_reset=1 at a clock edge set FSM=IDLE, phase counter=0, halt pending=0, o_w_debug_clk=0, o_w_running=0, o_w_bp_hit=0, o_w_cycle_count=0, overriding all other inputs, including mid-period.

Verification (p_half_period=2, p_count_width=16)
REQ-029 SHALL verify step: i_w_step pulse at edge 0 -> debug_clk 1 for edges 1-2, 0 edges 3-4, IDLE at 5, cycle_count=1, running=0.
REQ-030 SHALL verify run/halt: run pulse, halt pulse mid RUN_HIGH of 3rd period -> 3rd period completes, stop in IDLE, cycle_count=3, bp_hit=0.
REQ-031 SHALL verify breakpoint: bp_enable=1, bp_value=16'h0005, cpu_state advancing 0,1,2,... per debug-clock rise -> stop after 5th period, bp_hit=1, count=5; next step clears bp_hit.
REQ-032 SHALL verify simultaneous run+step+halt in IDLE -> no activity; run+step -> run accepted, running=1.
REQ-033 SHALL verify reset asserted during RUN_HIGH -> next edge debug_clk=0, count=0, running=0, bp_hit=0.
REQ-034 SHALL verify wrap: p_count_width=4, 17 steps -> cycle_count=1.
